sram_read_responder: RTL and testbench
======================================

# sram_read_responder

Memory-side responder for the cache's refill port. It accepts 32-bit word read requests on the four-phase `mem_valid`/`mem_ready` handshake and fetches each word from a 16-bit asynchronous SRAM as two halfword reads with programmable wait states. It returns the assembled word on `mem_rdata`. The block is read-only; the SRAM write strobe is never asserted.

## Interface
- `WAIT_STATES`, default 2: clock cycles per halfword SRAM access. Legal range 1..15.
- `clk` in 1: system clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_addr` in 17: byte address. Bits [1:0] are ignored.
- `mem_valid` in 1: request strobe from the cache.
- `mem_ready` out 1: response strobe. `mem_rdata` is valid while this is high.
- `mem_rdata` out 32: returned word. The low halfword comes from the even SRAM address.
- `sram_a` out 16: SRAM halfword address.
- `sram_d` in 16: SRAM read data.
- `sram_ce_n` out 1: chip enable, active low.
- `sram_oe_n` out 1: output enable, active low.
- `sram_we_n` out 1: write enable. Held at 1 at all times.
- `sram_ub_n` out 1: upper byte-lane enable, active low.
- `sram_lb_n` out 1: lower byte-lane enable, active low.

## Operation
- States: IDLE, RD_LO, RD_HI, DONE.
- Reset values, applied asynchronously while `rst_n`=0:
  - state = IDLE
  - `mem_ready`=0, `mem_rdata`=0
  - `sram_a`=0, `sram_ce_n`=1, `sram_oe_n`=1, `sram_we_n`=1, `sram_ub_n`=1, `sram_lb_n`=1
  - wait counter = 0, low-half shadow register = 0
- IDLE:
  - If `mem_valid`=1 and `mem_ready`=0, capture `mem_addr[16:2]` into `addr_q`.
  - Drive `sram_a`={addr_q,0}; set `ce_n`/`oe_n`/`ub_n`/`lb_n` to 0.
  - Load counter = WAIT_STATES-1 and go to RD_LO.
- RD_LO:
  - While counter≠0, decrement.
  - When counter=0: latch `sram_d` into the shadow register, drive `sram_a`={addr_q,1}, reload the counter, go to RD_HI.
- RD_HI: same counting.
  - When counter=0: load `mem_rdata`={`sram_d`, shadow}.
  - Deassert `ce_n`/`oe_n`/`ub_n`/`lb_n` (all to 1).
  - If `mem_valid`=1, set `mem_ready`=1 and go to DONE; otherwise go to IDLE with `mem_ready` left at 0 (abort).
- DONE:
  - Hold `mem_ready`=1 and `mem_rdata` stable while `mem_valid`=1.
  - The first cycle `mem_valid`=0 is sampled: clear `mem_ready` and go to IDLE.
- `mem_addr` is sampled only at acceptance. Changes during an access are ignored.
- Abort: if `mem_valid` falls during RD_LO/RD_HI, the SRAM access still completes its full wait count. No `mem_ready` pulse is produced, and `mem_rdata` is still updated.
- `mem_rdata` changes only on the RD_HI completion edge. The low halfword never appears on it early.

## Timing
- Let E0 be the edge that samples `mem_valid` in IDLE.
- `sram_a` holds the even address for WAIT_STATES cycles after E0, then the odd address for WAIT_STATES cycles.
- `mem_ready` rises at edge E0+2·WAIT_STATES. With WAIT_STATES=2 that is 4 cycles; with 1 it is 2 cycles.
- Data sampling: `sram_d` is sampled on the last edge of each halfword window. It has a full WAIT_STATES cycles of setup from the address change.
- `mem_ready` fall: one edge after `mem_valid`=0 is sampled in DONE.
- Minimum re-accept: the next request is accepted on the edge after `mem_ready` is seen low in IDLE. This matches the cache, which waits for `mem_ready`=0 before reissuing.
- `mem_valid` re-asserted while `mem_ready` is still 1 is not accepted. It is accepted once `mem_ready`=0.
- A reset mid-access returns all outputs to their reset values immediately. No response is issued for the interrupted request.

## Test plan
- Reset: hold `rst_n`=0 with `mem_valid`=1 → `mem_ready`=0, `sram_ce_n`=1, `sram_oe_n`=1, `sram_we_n`=1, `mem_rdata`=0 throughout.
- Basic read, WAIT_STATES=2, SRAM[0x0082]=0xBEEF, SRAM[0x0083]=0xDEAD, request `mem_addr`=0x00104:
  - `sram_a`=0x0082 for 2 cycles, then 0x0083 for 2 cycles.
  - `mem_ready`=1 at E0+4 with `mem_rdata`=0xDEADBEEF.
  - `mem_ready` falls one edge after `mem_valid` drops.
- Cache refill pattern: request 0x00108, then 0x0010C issued immediately after `mem_ready` falls (SRAM holds 0x11112222 / 0x33334444) → two responses in order, 0x11112222 then 0x33334444. `sram_we_n` is never 0.
- Low address bits and wrap: `mem_addr`=0x00107 returns the same word as 0x00104. `mem_addr`=0x1FFFC drives `sram_a`=0xFFFE then 0xFFFF.
- Abort: drop `mem_valid` one cycle after E0 with WAIT_STATES=3 → the SRAM cycle runs 6 cycles, no `mem_ready` pulse, and the block returns to IDLE. A new request afterwards is served normally.
- Reset mid-access: assert `rst_n`=0 during RD_HI → outputs go to reset values asynchronously. After release, a request for 0x00104 returns 0xDEADBEEF.

Source files
------------

// File: rtl/sram_read_responder.sv
// Word read responder for the cache refill port: each 32-bit request becomes two
// 16-bit asynchronous SRAM reads (even halfword first) with programmable wait states.
module sram_read_responder #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [16:0] mem_addr,
  input  logic        mem_valid,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [15:0] sram_a,
  input  logic [15:0] sram_d,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  // state  | meaning
  // IDLE   | waiting for mem_valid with mem_ready low
  // RD_LO  | even halfword on the bus, counting wait states
  // RD_HI  | odd halfword on the bus, counting wait states
  // DONE   | mem_ready high, waiting for mem_valid to drop
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);

  state_t      state_q, state_d;
  logic [14:0] addr_q, addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] sram_a_q, sram_a_d;
  logic        en_n_q, en_n_d;

  // Byte offset within the word has no meaning for a word-only port.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^mem_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      sram_a_q <= '0;
      en_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      sram_a_q <= sram_a_d;
      en_n_q   <= en_n_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    ready_d  = ready_q;
    rdata_d  = rdata_q;
    sram_a_d = sram_a_q;
    en_n_d   = en_n_q;
    unique case (state_q)
      IDLE: begin
        if (mem_valid && !ready_q) begin
          addr_d   = mem_addr[16:2];
          sram_a_d = {mem_addr[16:2], 1'b0};
          en_n_d   = 1'b0;
          cnt_d    = WS_M1;
          state_d  = RD_LO;
        end
      end
      RD_LO: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          shadow_d = sram_d;
          sram_a_d = {addr_q, 1'b1};
          cnt_d    = WS_M1;
          state_d  = RD_HI;
        end
      end
      RD_HI: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // The access always runs to completion; a dropped request only
          // suppresses the mem_ready pulse.
          rdata_d = {sram_d, shadow_q};
          en_n_d  = 1'b1;
          if (mem_valid) begin
            ready_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        if (!mem_valid) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign sram_a    = sram_a_q;
  assign sram_ce_n = en_n_q;
  assign sram_oe_n = en_n_q;
  assign sram_ub_n = en_n_q;
  assign sram_lb_n = en_n_q;
  assign sram_we_n = 1'b1;

endmodule

// File: tb/tb_sram_read_responder.sv
// Bench for sram_read_responder: two instances (2 and 3 wait states) on a shared
// SRAM image, with a per-instance scoreboard of expected response words.
module tb_sram_read_responder;

  logic              clk;
  logic              rst_n;
  logic [1:0][16:0]  mem_addr;
  logic [1:0]        mem_valid;
  logic [1:0]        mem_ready;
  logic [1:0][31:0]  mem_rdata;
  logic [1:0][15:0]  sram_a;
  logic [1:0][15:0]  sram_d;
  logic [1:0]        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic [15:0] sram_mem [0:65535];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [1:0]  ready_prev;
  logic        we_low_seen;
  int          n_tests;
  int          n_fail;

  sram_read_responder #(.WAIT_STATES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr[0]), .mem_valid(mem_valid[0]),
    .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0]), .sram_a(sram_a[0]),
    .sram_d(sram_d[0]), .sram_ce_n(sram_ce_n[0]), .sram_oe_n(sram_oe_n[0]),
    .sram_we_n(sram_we_n[0]), .sram_ub_n(sram_ub_n[0]), .sram_lb_n(sram_lb_n[0])
  );

  sram_read_responder #(.WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr[1]), .mem_valid(mem_valid[1]),
    .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1]), .sram_a(sram_a[1]),
    .sram_d(sram_d[1]), .sram_ce_n(sram_ce_n[1]), .sram_oe_n(sram_oe_n[1]),
    .sram_we_n(sram_we_n[1]), .sram_ub_n(sram_ub_n[1]), .sram_lb_n(sram_lb_n[1])
  );

  assign sram_d[0] = sram_mem[sram_a[0]];
  assign sram_d[1] = sram_mem[sram_a[1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every rising mem_ready must match the oldest expected word.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_ready[k] && !ready_prev[k]) begin
        if (k == 0) begin
          if (exp_q0.size() == 0) check_val("unexpected_ready0", 32'd1, 32'd0);
          else check_val("rdata0", mem_rdata[0], exp_q0.pop_front());
        end else begin
          if (exp_q1.size() == 0) check_val("unexpected_ready1", 32'd1, 32'd0);
          else check_val("rdata1", mem_rdata[1], exp_q1.pop_front());
        end
      end
    end
    if (sram_we_n != 2'b11) we_low_seen <= 1'b1;
    ready_prev <= mem_ready;
  end

  task automatic do_read(input int k, input logic [16:0] addr, input logic [31:0] exp,
                         input int ws);
    int n;
    logic [15:0] even_a, odd_a;
    even_a = {addr[16:2], 1'b0};
    odd_a  = {addr[16:2], 1'b1};
    n = 0;
    while (mem_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_before_req", 32'(mem_ready[k]), 32'd0);
    mem_addr[k]  = addr;
    mem_valid[k] = 1'b1;
    if (k == 0) exp_q0.push_back(exp); else exp_q1.push_back(exp);
    @(posedge clk);
    for (int i = 1; i <= 2 * ws; i++) begin
      @(negedge clk);
      if (i == 1) mem_addr[k] = addr ^ 17'h1FFF0;
      check_val("sram_a", 32'(sram_a[k]), 32'(i <= ws ? even_a : odd_a));
      check_val("ready_early", 32'(mem_ready[k]), 32'd0);
      check_val("ce_active", 32'(sram_ce_n[k]), 32'd0);
    end
    @(negedge clk);
    check_val("ready_rise", 32'(mem_ready[k]), 32'd1);
    check_val("ce_released", 32'(sram_ce_n[k]), 32'd1);
    @(negedge clk);
    check_val("ready_hold", 32'(mem_ready[k]), 32'd1);
    check_val("rdata_hold", mem_rdata[k], exp);
    mem_valid[k] = 1'b0;
    @(negedge clk);
    check_val("ready_fall", 32'(mem_ready[k]), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    we_low_seen = 1'b0;
    ready_prev = 2'b00;
    mem_valid = 2'b11;
    mem_addr = '0;
    rst_n = 1'b0;
    sram_mem[16'h0082] = 16'hBEEF;
    sram_mem[16'h0083] = 16'hDEAD;
    sram_mem[16'h0084] = 16'h2222;
    sram_mem[16'h0085] = 16'h1111;
    sram_mem[16'h0086] = 16'h4444;
    sram_mem[16'h0087] = 16'h3333;
    sram_mem[16'hFFFE] = 16'hAAAA;
    sram_mem[16'hFFFF] = 16'h5555;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("rst_ready", 32'(mem_ready[0]), 32'd0);
      check_val("rst_ce_n", 32'(sram_ce_n[0]), 32'd1);
      check_val("rst_oe_n", 32'(sram_oe_n[0]), 32'd1);
      check_val("rst_we_n", 32'(sram_we_n[0]), 32'd1);
      check_val("rst_rdata", mem_rdata[0], 32'd0);
    end
    mem_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);

    do_read(0, 17'h00104, 32'hDEADBEEF, 2);
    do_read(0, 17'h00108, 32'h11112222, 2);
    do_read(0, 17'h0010C, 32'h33334444, 2);
    do_read(0, 17'h00107, 32'hDEADBEEF, 2);
    do_read(0, 17'h1FFFC, 32'h5555AAAA, 2);
    do_read(1, 17'h0010C, 32'h33334444, 3);

    // Abort on the 3-wait-state instance: request dropped one cycle after acceptance.
    mem_addr[1] = 17'h00104;
    mem_valid[1] = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) mem_valid[1] = 1'b0;
      if (i <= 6) check_val("abort_ce_active", 32'(sram_ce_n[1]), 32'd0);
      else check_val("abort_ce_idle", 32'(sram_ce_n[1]), 32'd1);
      check_val("abort_no_ready", 32'(mem_ready[1]), 32'd0);
    end
    check_val("abort_rdata", mem_rdata[1], 32'hDEADBEEF);
    do_read(1, 17'h00108, 32'h11112222, 3);

    // Reset in the middle of the odd-halfword read.
    mem_addr[0] = 17'h00104;
    mem_valid[0] = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_ready", 32'(mem_ready[0]), 32'd0);
    check_val("arst_rdata", mem_rdata[0], 32'd0);
    check_val("arst_sram_a", 32'(sram_a[0]), 32'd0);
    check_val("arst_ce_n", 32'(sram_ce_n[0]), 32'd1);
    check_val("arst_oe_n", 32'(sram_oe_n[0]), 32'd1);
    check_val("arst_lanes", 32'({sram_ub_n[0], sram_lb_n[0]}), 32'd3);
    mem_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(0, 17'h00104, 32'hDEADBEEF, 2);

    repeat (3) @(negedge clk);
    check_val("sb_drain0", exp_q0.size(), 32'd0);
    check_val("sb_drain1", exp_q1.size(), 32'd0);
    check_val("we_never_low", 32'(we_low_seen), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
